spi_flash_responder: RTL

Synthesizable SPI-flash target that answers the bootloader's SPI master from the flash side of the bus: it oversamples SCK/CS/MOSI on the 48 MHz clock and drives MISO. It supports a byte-readable memory port, so simulation benches and loopback bring-up boards can exercise flash read, ID and status traffic without a physical QSPI device. Commands supported: READ (0x03), JEDEC ID (0x9F) and READ STATUS (0x05). Every other opcode is ignored until CS deasserts.

---
 rtl/spi_flash_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/spi_flash_responder.sv
// SPI-flash target (mode 0) answering READ 0x03, JEDEC ID 0x9F and READ STATUS 0x05.
// All SPI pins are oversampled on clk_48mhz; reads go to a fixed 1-cycle-latency byte port.
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter logic [7:0]  STATUS   = 8'h00
) (
    input  logic        clk_48mhz,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, ID_DATA, ST_DATA, IGNORE} state_t;

    localparam logic [7:0] STATUS_BYTE = {STATUS[7:1], 1'b0};

    state_t      state, state_next;
    logic [2:0]  sck_s;
    logic [1:0]  cs_s, mosi_s;
    logic        cs_hi, sck_rise, sck_fall, mosi;
    logic        armed, oe_on, rd_pend;
    logic [4:0]  bit_cnt;
    logic [2:0]  tx_cnt;
    logic [1:0]  id_idx;
    logic [22:0] in_sr;
    logic [7:0]  tx_sr, id_byte, cmd_byte;
    logic [23:0] addr_word;
    logic        hdr_shift, data_fall, cmd_done, addr_done;

    // Synchronizers reset to "selected" so a reset with CS held low cannot re-arm the block.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            sck_s  <= '0;
            cs_s   <= '0;
            mosi_s <= '0;
        end else begin
            sck_s  <= {sck_s[1:0], spi_sck};
            cs_s   <= {cs_s[0], spi_cs};
            mosi_s <= {mosi_s[0], spi_mosi};
        end
    end

    assign cs_hi     = cs_s[1];
    assign mosi      = mosi_s[1];
    assign sck_rise  = sck_s[1] & ~sck_s[2] & ~cs_hi;
    assign sck_fall  = ~sck_s[1] & sck_s[2] & ~cs_hi;
    assign cmd_byte  = {in_sr[6:0], mosi};
    assign addr_word = {in_sr, mosi};

    always_comb begin
        case (id_idx)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            default: id_byte = JEDEC_ID[7:0];
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cs_hi) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (armed) state_next = CMD;
                CMD: if (cmd_done) begin
                    case (cmd_byte)
                        8'h03:   state_next = ADDR;
                        8'h9F:   state_next = ID_DATA;
                        8'h05:   state_next = ST_DATA;
                        default: state_next = IGNORE;
                    endcase
                end
                ADDR: if (addr_done) state_next = RD_DATA;
                default: ;
            endcase
        end
    end

    always_comb begin
        hdr_shift   = 1'b0;
        data_fall   = 1'b0;
        cmd_done    = 1'b0;
        addr_done   = 1'b0;
        spi_miso_oe = 1'b0;
        case (state)
            CMD: begin
                hdr_shift = sck_rise;
                cmd_done  = sck_rise && (bit_cnt == 5'd7);
            end
            ADDR: begin
                hdr_shift = sck_rise;
                addr_done = sck_rise && (bit_cnt == 5'd23);
            end
            RD_DATA, ID_DATA, ST_DATA: begin
                data_fall   = sck_fall;
                spi_miso_oe = oe_on;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            armed    <= 1'b0;
            oe_on    <= 1'b0;
            spi_miso <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            rd_pend  <= 1'b0;
            bit_cnt  <= '0;
            tx_cnt   <= '0;
            id_idx   <= '0;
            in_sr    <= '0;
            tx_sr    <= '0;
        end else begin
            mem_rd  <= 1'b0;
            rd_pend <= mem_rd;
            if (cs_hi) armed <= 1'b1;
            if (cs_hi || state == IDLE) begin
                bit_cnt  <= '0;
                tx_cnt   <= '0;
                oe_on    <= 1'b0;
                spi_miso <= 1'b0;
            end else begin
                if (hdr_shift) begin
                    in_sr   <= addr_word[22:0];
                    bit_cnt <= (cmd_done || addr_done) ? 5'd0 : bit_cnt + 5'd1;
                end
                if (cmd_done) begin
                    if (cmd_byte == 8'h9F) begin
                        tx_sr  <= JEDEC_ID[23:16];
                        id_idx <= 2'd1;
                    end else begin
                        tx_sr <= STATUS_BYTE;
                    end
                end
                if (addr_done) begin
                    mem_addr <= addr_word;
                    mem_rd   <= 1'b1;
                end
                // Read data lands well before the next falling edge, so no collision with shifting.
                if (state == RD_DATA && rd_pend) tx_sr <= mem_rdata;
                if (data_fall) begin
                    oe_on    <= 1'b1;
                    spi_miso <= tx_sr[7];
                    tx_sr    <= {tx_sr[6:0], 1'b0};
                    tx_cnt   <= tx_cnt + 3'd1;
                    if (tx_cnt == 3'd7) begin
                        case (state)
                            RD_DATA: begin
                                mem_addr <= mem_addr + 24'd1;
                                mem_rd   <= 1'b1;
                            end
                            ID_DATA: begin
                                tx_sr  <= id_byte;
                                id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                            end
                            default: tx_sr <= STATUS_BYTE;
                        endcase
                    end
                end
            end
        end
    end

endmodule
